// File: rtl/mix_pkg.sv
// Shared types and column maps for the iterative column mixing layer.
// Pure combinational helpers, no state; used by mix_col and the top level.
// Column maps are GF(2) XOR networks on a single 16-bit column.
package mix_pkg;

  localparam int COL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward column map: b = input column, returns c.
  function automatic logic [COL_W-1:0] col_fwd(input logic [COL_W-1:0] b);
    logic [COL_W-1:0] c;
    c[3:0]   = b[15:12] ^ b[11:8];
    c[7:4]   = b[3:0];
    c[8]     = b[3] ^ b[4];
    c[9]     = b[0] ^ b[5];
    c[10]    = b[1] ^ b[6];
    c[11]    = b[2] ^ b[3] ^ b[7];
    c[15:12] = b[11:8];
    return c;
  endfunction

  // Inverse column map: c = input column, returns b.
  function automatic logic [COL_W-1:0] col_inv(input logic [COL_W-1:0] c);
    logic [COL_W-1:0] b;
    b[3:0]   = c[7:4];
    b[11:8]  = c[15:12];
    b[15:12] = c[3:0] ^ c[15:12];
    b[4]     = c[8] ^ c[7];
    b[5]     = c[9] ^ c[4];
    b[6]     = c[10] ^ c[5];
    b[7]     = c[11] ^ c[6] ^ c[7];
    return b;
  endfunction

endpackage

// File: rtl/mix_col.sv
// One 16-bit column of the mixing layer, forward or inverse map.
// Combinational, zero latency; no handshake of its own.
// Inverse path exists only when MIX_INV_EN is defined; otherwise inv_i is ignored.
module mix_col
  import mix_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

`ifdef MIX_INV_EN
  assign col_o = inv_i ? col_inv(col_i) : col_fwd(col_i);
`else
  // Select is tied off at the top in this build; keep it visibly unused.
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = col_fwd(col_i);
`endif

endmodule

// File: rtl/mix_layer_iter.sv
// Iterative column mixing layer: applies the column map in_count times, one pass per clock.
// Latency 1+in_count cycles from input handshake to out_valid; count 0 is a one-cycle pass-through.
// Accepts only in IDLE; result is held in DONE until out_ready. Optional inverse map via MIX_INV_EN.
module mix_layer_iter
  import mix_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL_W*NUM_COLS-1:0] in_data,
  input  logic [CNT_W-1:0]          in_count,
  input  logic                      in_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL_W*NUM_COLS-1:0] out_data,
  input  logic                      flush
);

  localparam int ST_W = COL_W * NUM_COLS;

  state_e           state_q, state_d;
  logic [ST_W-1:0]  data_q, data_d;
  logic [ST_W-1:0]  mixed;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;

  // Columns are independent: one map instance per column, all fed by the data register.
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    mix_col u_col (
      .col_i (data_q[COL_W*j +: COL_W]),
      .inv_i (inv_q),
      .col_o (mixed[COL_W*j +: COL_W])
    );
  end

`ifndef MIX_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  // Next-state, counter and data update; flush overrides everything but reset.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    if (flush) begin
      // Data register deliberately left as-is; only control is aborted.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = in_count;
`ifdef MIX_INV_EN
            inv_d   = in_inv;
`else
            inv_d   = 1'b0;
`endif
            state_d = (in_count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          data_d = mixed;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // No same-cycle re-accept: IDLE is entered first, in_ready follows.
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_mix_layer_iter.sv
// Bench for mix_layer_iter: directed jobs checked against a transaction-level model.
// The model tracks job acceptance, expected completion cycle and the mixed result.
// Optional inverse tests are compiled in when MIX_INV_EN is defined.
module tb_mix_layer_iter;

  localparam int NC = 4;
  localparam int CW = 4;
  localparam int SW = 16 * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_data = '0;
  logic [CW-1:0] in_count = '0;
  logic          in_inv = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_data;
  logic          flush = 1'b0;

  int checks = 0;
  int errors = 0;

  mix_layer_iter #(.NUM_COLS(NC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (nibble-level algebra) ----------------
  function automatic logic [3:0] mixn(input logic [3:0] x);
    return {x[2:0], x[3]} ^ {x[3], 3'b000};
  endfunction

  function automatic logic [15:0] ref_fwd(input logic [15:0] b);
    return {b[11:8], mixn(b[3:0]) ^ b[7:4], b[3:0], b[15:12] ^ b[11:8]};
  endfunction

  function automatic logic [15:0] ref_inv(input logic [15:0] c);
    return {c[3:0] ^ c[15:12], c[15:12], c[11:8] ^ mixn(c[7:4]), c[7:4]};
  endfunction

  function automatic logic [SW-1:0] ref_apply(input logic [SW-1:0] s, input int k, input bit inv);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < NC; j++)
        r[16*j +: 16] = inv ? ref_inv(r[16*j +: 16]) : ref_fwd(r[16*j +: 16]);
    return r;
  endfunction

  // Model state: one outstanding job at most.
  bit            m_pending = 1'b0;
  logic [SW-1:0] m_exp = '0;
  int            m_vcyc = 0;
  int            cyc = 0;

  function automatic bit model_inv();
`ifdef MIX_INV_EN
    return in_inv;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
    end else begin
      if (flush) begin
        m_pending = 1'b0;
      end else if (m_pending) begin
        if (cyc >= m_vcyc && out_ready) m_pending = 1'b0;
      end else if (in_valid) begin
        m_pending = 1'b1;
        m_exp     = ref_apply(in_data, int'(in_count), model_inv());
        m_vcyc    = cyc + 1 + int'(in_count);
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(!m_pending));
      chk("out_valid", 64'(out_valid), 64'(m_pending && cyc >= m_vcyc));
      if (m_pending && cyc >= m_vcyc) chk("out_data", out_data, m_exp);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    for (int n = 0; n < 200 && m_pending; n++) @(negedge clk);
    if (m_pending) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_job(input logic [SW-1:0] d, input int k, input bit inv, output int lat);
    int t0;
    bit seen;
    wait_idle();
    in_data  = d;
    in_count = CW'(k);
    in_inv   = inv;
    in_valid = 1'b1;
    t0       = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_inv   = 1'b0;
    seen     = 1'b0;
    lat      = -1;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("out_valid_timeout", 64'd1, 64'd0);
    chk("latency", 64'(lat), 64'(1 + k));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int            lat;
    logic [SW-1:0] r, y;
    int            k;

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single forward pass on column 0.
    run_job(64'h0000_0000_0000_0001, 1, 1'b0, lat);
    chk("cnt1_col0", 64'(out_data[15:0]), 64'h0210);
    chk("cnt1_upper", 64'(out_data[63:16]), 64'd0);

    // Two passes.
    run_job(64'h0000_0000_0000_0001, 2, 1'b0, lat);
    chk("cnt2_col0", 64'(out_data[15:0]), 64'h2102);

    // Pass-through with downstream stalled for three cycles.
    wait_idle();
    out_ready = 1'b0;
    run_job(64'h0123_4567_89AB_CDEF, 0, 1'b0, lat);
    chk("cnt0_data", out_data, 64'h0123_4567_89AB_CDEF);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, 64'h0123_4567_89AB_CDEF);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // Assorted forward jobs, including maximum count.
    run_job(64'hFFFF_0000_A5A5_1234, 15, 1'b0, lat);
    run_job(64'h8000_0001_0F0F_F0F0, 3, 1'b0, lat);
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom};
      run_job(r, int'($urandom_range(0, 7)), 1'b0, lat);
    end

`ifdef MIX_INV_EN
    run_job(64'h0000_0000_0000_0210, 1, 1'b1, lat);
    chk("inv_col0", 64'(out_data[15:0]), 64'h0001);
    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom};
      k = int'($urandom_range(1, 15));
      run_job(r, k, 1'b0, lat);
      y = out_data;
      run_job(y, k, 1'b1, lat);
      chk("inv_roundtrip", out_data, r);
    end
`endif

    // Flush in the second RUN cycle of a count=5 job.
    wait_idle();
    in_data  = 64'h0000_0000_0000_0001;
    in_count = CW'(5);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_data_kept", 64'(out_data[15:0]), 64'h0210);
    run_job(64'h0000_0000_0000_0001, 1, 1'b0, lat);
    chk("post_flush_col0", 64'(out_data[15:0]), 64'h0210);

    // Asynchronous reset in the middle of a long job.
    wait_idle();
    in_data  = 64'hDEAD_BEEF_CAFE_F00D;
    in_count = CW'(10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(64'h0000_0000_0000_0001, 2, 1'b0, lat);
    chk("post_rst_col0", 64'(out_data[15:0]), 64'h2102);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
